// File: rtl/mux_sel_stream.sv
// N-to-1 valid/ready stream selector with a single registered output stage.
// Channel chosen by explicit select or by round-robin over the valid inputs.
module mux_sel_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 9,
    parameter int unsigned SELW  = 4
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic                  rr_mode,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_chan,
    output logic                  sel_err
);

    localparam int unsigned SW1  = SELW + 1;
    localparam int unsigned DBLW = 2 * NCH;

    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic             out_valid_d, out_valid_q;
    logic [SELW-1:0]  out_chan_d,  out_chan_q;
    logic             sel_err_d,   sel_err_q;
    logic [SELW-1:0]  ptr_d,       ptr_q;

    logic             load_en_c;
    logic             sel_ok_c;
    logic [SELW-1:0]  rr_start_c;
    logic [DBLW-1:0]  rr_dbl_c;
    logic [NCH-1:0]   rr_rot_c;
    logic             rr_hit_c;
    logic [SELW-1:0]  rr_off_c;
    logic [SW1-1:0]   rr_sum_c;
    logic [SELW-1:0]  rr_idx_c;
    logic             cand_ok_c;
    logic [SELW-1:0]  cand_c;
    logic [NCH-1:0]   grant_c;
    logic             xfer_c;
    logic [WIDTH-1:0] grant_data_c;

    assign load_en_c = !out_valid_q || out_ready;
    assign sel_ok_c  = ({1'b0, sel} < SW1'(NCH));

    // Round-robin: rotate valids so the bit after the pointer sits at index 0.
    always_comb begin
        rr_start_c = (ptr_q >= SELW'(NCH - 1)) ? '0 : ptr_q + SELW'(1);
        rr_dbl_c   = {in_valid, in_valid} >> rr_start_c;
        rr_rot_c   = rr_dbl_c[NCH-1:0];
        rr_hit_c   = 1'b0;
        rr_off_c   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!rr_hit_c && rr_rot_c[i]) begin
                rr_hit_c = 1'b1;
                rr_off_c = SELW'(i);
            end
        end
        rr_sum_c = {1'b0, rr_start_c} + {1'b0, rr_off_c};
        if (rr_sum_c >= SW1'(NCH)) begin
            rr_sum_c = rr_sum_c - SW1'(NCH);
        end
        rr_idx_c = rr_sum_c[SELW-1:0];
    end

    // Candidate and one-hot grant; out-of-range candidates decode to no grant.
    always_comb begin
        if (rr_mode) begin
            cand_ok_c = rr_hit_c;
            cand_c    = rr_idx_c;
        end else begin
            cand_ok_c = sel_ok_c;
            cand_c    = sel;
        end
        grant_c = (load_en_c && cand_ok_c) ? (NCH'(1) << cand_c) : '0;
        xfer_c  = |(grant_c & in_valid);
        grant_data_c = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_c[k]) begin
                grant_data_c = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = areset ? '0 : grant_c;

    // Next-state for the output stage, pointer and error flag.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        sel_err_d   = !rr_mode && !sel_ok_c;
        if (load_en_c) begin
            out_valid_d = xfer_c;
            if (xfer_c) begin
                out_data_d = grant_data_c;
                out_chan_d = cand_c;
            end
        end
        if (xfer_c && rr_mode) begin
            ptr_d = cand_c;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_data_q  <= '1;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            sel_err_q   <= 1'b0;
            ptr_q       <= SELW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_stream.sv
// Scoreboard bench for mux_sel_stream: a behavioural model predicts grants,
// queues accepted beats and checks them as the output stage delivers them.
module tb_mux_sel_stream;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NCH   = 9;
    localparam int unsigned SELW  = 4;
    localparam int unsigned BEATW = SELW + WIDTH;

    logic                 clk;
    logic                 areset;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [SELW-1:0]      sel;
    logic                 rr_mode;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_chan;
    logic                 sel_err;

    mux_sel_stream #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk(clk), .areset(areset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .rr_mode(rr_mode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [BEATW-1:0] sb_q[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_chan;
    int               m_ptr;
    logic             m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '1;
        m_chan  = 0;
        m_ptr   = NCH - 1;
        m_err   = 1'b0;
        sb_q.delete();
    endtask

    task automatic set_ch(input int k, input logic [WIDTH-1:0] d);
        in_data[k*WIDTH +: WIDTH] = d;
    endtask

    // One clock: called at the falling edge with inputs already applied.
    task automatic step();
        logic             load;
        logic             cv;
        int               cand;
        int               j;
        logic [NCH-1:0]   exp_rdy;
        logic             xfer;
        logic [BEATW-1:0] beat;
        #1;
        load = !m_valid || out_ready;
        cv   = 1'b0;
        cand = 0;
        if (!rr_mode) begin
            cv   = (int'(sel) < NCH);
            cand = int'(sel);
        end else begin
            for (int i = 1; i <= NCH; i++) begin
                j = (m_ptr + i) % NCH;
                if (!cv && in_valid[j]) begin
                    cv   = 1'b1;
                    cand = j;
                end
            end
        end
        exp_rdy = '0;
        if (load && cv) exp_rdy[cand] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        xfer = load && cv && in_valid[cand];
        if (m_valid && out_ready) begin
            chk("sb_has_beat", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                beat = sb_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(beat[WIDTH-1:0]));
                chk("sb_chan", 32'(out_chan), 32'(beat[BEATW-1:WIDTH]));
            end
        end
        if (load) m_valid = xfer;
        if (xfer) begin
            m_data = in_data[cand*WIDTH +: WIDTH];
            m_chan = cand;
            sb_q.push_back({SELW'(cand), m_data});
            if (rr_mode) m_ptr = cand;
        end
        m_err = !rr_mode && (int'(sel) >= NCH);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_chan", 32'(out_chan), 32'(m_chan));
        chk("sel_err", 32'(sel_err), 32'(m_err));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset    = 1'b1;
        in_valid  = '1;
        sel       = '0;
        rr_mode   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < NCH; k++) set_ch(k, WIDTH'(16'hC000 + k * 16'h0111));
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'hFFFF);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        areset   = 1'b0;
        in_valid = '0;

        // Fixed select of channel 5
        sel = 4'd5;
        set_ch(5, 16'h1234);
        in_valid = 9'h020;
        #1 chk("t1_in_ready", 32'(in_ready), 32'h020);
        step();
        chk("t1_data", 32'(out_data), 32'h1234);
        chk("t1_chan", 32'(out_chan), 32'd5);
        chk("t1_valid", 32'(out_valid), 32'd1);

        // Out-of-range selects
        in_valid = '1;
        sel = 4'd9;
        step();
        chk("t2_valid9", 32'(out_valid), 32'd0);
        chk("t2_hold9", 32'(out_data), 32'h1234);
        chk("t2_err9", 32'(sel_err), 32'd1);
        sel = 4'd15;
        step();
        chk("t2_err15", 32'(sel_err), 32'd1);

        // Backpressure on a held beat
        sel = 4'd3;
        set_ch(3, 16'hAAAA);
        in_valid = 9'h008;
        step();
        out_ready = 1'b0;
        sel = 4'd0;
        set_ch(0, 16'h5555);
        in_valid = 9'h001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_held", 32'(out_data), 32'hAAAA);
        end
        out_ready = 1'b1;
        step();
        chk("t3_nobubble_v", 32'(out_valid), 32'd1);
        chk("t3_nobubble_d", 32'(out_data), 32'h5555);
        in_valid = '0;
        step();

        // Round-robin over all channels, with wrap
        for (int k = 0; k < NCH; k++) set_ch(k, WIDTH'(16'h0100 + k));
        rr_mode  = 1'b1;
        in_valid = '1;
        for (int i = 0; i <= NCH; i++) begin
            step();
            chk("t4_chan", 32'(out_chan), 32'(i % NCH));
        end

        // Sparse round-robin, then a fixed-mode interlude
        in_valid = 9'h004;
        step();
        chk("t5_p2", 32'(out_chan), 32'd2);
        in_valid = 9'h084;
        step(); chk("t5_g7a", 32'(out_chan), 32'd7);
        step(); chk("t5_g2", 32'(out_chan), 32'd2);
        step(); chk("t5_g7b", 32'(out_chan), 32'd7);
        rr_mode  = 1'b0;
        sel      = 4'd4;
        in_valid = 9'h010;
        step();
        step();
        rr_mode  = 1'b1;
        in_valid = 9'h084;
        step();
        chk("t5_resume", 32'(out_chan), 32'd2);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = NCH'($urandom);
            rr_mode   = 1'($urandom_range(0, 1));
            sel       = SELW'($urandom_range(0, 11));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NCH; k++) set_ch(k, WIDTH'($urandom));
            step();
        end

        // Async reset with a held beat
        in_valid = '0;
        out_ready = 1'b1;
        step();
        rr_mode  = 1'b0;
        sel      = 4'd1;
        set_ch(1, 16'hBEEF);
        in_valid = 9'h002;
        out_ready = 1'b0;
        step();
        chk("t6_pre_data", 32'(out_data), 32'hBEEF);
        #2 areset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'hFFFF);
        chk("t6_rst_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        areset    = 1'b0;
        rr_mode   = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        step();
        chk("t6_first_rr", 32'(out_chan), 32'd0);

        // Drain
        in_valid = '0;
        repeat (3) step();
        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_stream.md
Name: mux_sel_stream

Overview:
Parametrised N-to-1 streaming selector, the registered successor to the combinational 9-to-1 select mux. It takes NCH valid/ready input channels and forwards one beat per cycle through a single output register stage. A channel is chosen either by an explicit select or by round-robin arbitration. The block sits between parallel producers and a single downstream consumer.

Parameters:
WIDTH, 16, data width per channel
NCH, 9, number of input channels (2..16)
SELW, 4, select/channel-index width; must be >= clog2(NCH)

Ports:
clk  input  1  clock, rising edge
areset  input  1  asynchronous active-high reset
in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready (combinational)
sel  input  SELW  channel select, used when rr_mode=0
rr_mode  input  1  0 = fixed select, 1 = round-robin
out_data  output  WIDTH  registered data
out_valid  output  1  registered valid
out_ready  input  1  downstream ready
out_chan  output  SELW  index of the channel held in out_data
sel_err  output  1  registered; high the cycle after an out-of-range sel is used in fixed mode

Behaviour:
- Reset (areset high, async): out_valid=0, out_data=all ones, out_chan=0, sel_err=0, rr pointer=NCH-1, so channel 0 has first priority. in_ready is 0 for every channel while areset is high.
- load_en = !out_valid || out_ready. This gives full throughput: one beat per cycle under continuous out_ready.
- Candidate channel c:
  - Fixed mode: c = sel, valid only if sel < NCH.
  - RR mode: c = first k with in_valid[k]=1, scanning ptr+1, ptr+2, ... modulo NCH.
- in_ready[k] = load_en && candidate valid && (k == c). Every other in_ready bit is 0. In fixed mode, in_ready[sel] is asserted regardless of in_valid[sel].
- Transfer on channel k occurs when in_valid[k] && in_ready[k]. On the next edge: out_data=in_data[k], out_chan=k, out_valid=1. Latency is 1 cycle from input handshake to out_valid.
- When load_en=1 and no transfer occurs, out_valid goes to 0. out_data and out_chan hold their last values.
- When out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable. No input is accepted.
- RR pointer updates to k only on a transfer. It is unchanged when rr_mode=0 and is never reset by a mode change. Wrap-around: from ptr=NCH-1, the scan starts at channel 0.
- Out-of-range sel (sel >= NCH) in fixed mode:
  - No channel is readied and no beat is produced.
  - sel_err is registered high for each such cycle, independent of load_en.
  - sel_err=0 in RR mode.
- rr_mode and sel may change on any cycle. They take effect combinationally for that cycle's candidate. A beat already in the output register is unaffected.
- Simultaneous unload and load (out_valid=1, out_ready=1, new transfer): the old beat is consumed and the new beat is registered on the same edge. No bubble.
- areset asserted mid-stream: the held beat is discarded (out_valid=0 immediately) and the pointer returns to NCH-1.

Test Plan:
1. Fixed mode, sel=5, in_data ch5=16'h1234, in_valid=9'h020, out_ready=1 -> in_ready=9'h020; next cycle out_data=16'h1234, out_chan=5, out_valid=1.
2. Fixed mode, sel=9 (and sel=15), all in_valid=1 -> in_ready=0, out_valid falls to 0, out_data holds last value, sel_err=1 the following cycle.
3. Backpressure: beat 16'hAAAA held with out_ready=0 for 3 cycles while ch0 valid -> out_data stays 16'hAAAA, in_ready=0. Release out_ready -> ch0 beat appears next cycle with no bubble.
4. RR mode, all 9 channels valid, out_ready=1 -> out_chan sequence 0,1,...,8,0 (wrap); one beat per cycle.
5. RR mode, only ch2 and ch7 valid, pointer=2 -> grant 7, then 2, then 7. Switch to fixed mode for 2 beats and back to RR -> scan resumes from the retained pointer.
6. Assert areset while out_valid=1 with data 16'hBEEF -> out_valid=0 and out_data=16'hFFFF without waiting for a clock edge. After release, the first RR grant is ch0.
